// File: rtl/alu_link_pkg.sv
// rtl/alu_link_pkg.sv - shared constants and state encoding for the UART ALU link
package alu_link_pkg;

  // Default widths; the device-side command interface uses the same values.
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  // Byte index within a three-byte command frame.
  localparam int NB_IDX = 2;
  localparam logic [NB_IDX-1:0] IDX_A  = 2'd0;
  localparam logic [NB_IDX-1:0] IDX_B  = 2'd1;
  localparam logic [NB_IDX-1:0] IDX_OP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_WAIT_RX = 2'd3
  } link_state_e;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - response timeout counter with clear, enable and expiry pulse
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int NB_TIMEOUT     = 21
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count_q, count_d;

  // Clear has priority; the counter only advances while enabled.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + NB_TIMEOUT'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged during the last enabled cycle of the window.
  assign o_expire = i_enable && !i_clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/alu_cmd_sender.sv
// rtl/alu_cmd_sender.sv - host-side ALU command initiator over tx_uart/rx_uart
module alu_cmd_sender
  import alu_link_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int NB_TIMEOUT     = 21
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  output logic               o_busy,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout
);

  link_state_e         state_q, state_d;
  logic [NB_IDX-1:0]   idx_q, idx_d;
  logic [NB_DATA-1:0]  a_q, a_d;
  logic [NB_DATA-1:0]  b_q, b_d;
  logic [NB_OP-1:0]    op_q, op_d;
  logic                busy_q, busy_d;
  logic                tx_start_q, tx_start_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic [NB_DATA-1:0]  result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                timeout_q, timeout_d;
  logic                tmo_clear;
  logic                tmo_expire;
  logic [NB_DATA-1:0]  frame_byte;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NB_TIMEOUT    (NB_TIMEOUT)
  ) u_timeout_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (tmo_clear),
    .i_enable(state_q == ST_WAIT_RX),
    .o_expire(tmo_expire)
  );

  // Select the frame byte for the current index: A, B, then zero-extended opcode.
  always_comb begin
    frame_byte = NB_DATA'(op_q);
    case (idx_q)
      IDX_A:   frame_byte = a_q;
      IDX_B:   frame_byte = b_q;
      default: frame_byte = NB_DATA'(op_q);
    endcase
  end

  // Next-state and registered-output logic for the command sequence.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;
    tmo_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          op_d    = i_operation;
          idx_d   = IDX_A;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_start_d = 1'b1;
        tx_data_d  = frame_byte;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done_tick) begin
          if (idx_q == IDX_OP) begin
            tmo_clear = 1'b1;
            state_d   = ST_WAIT_RX;
          end else begin
            idx_d   = idx_q + NB_IDX'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_WAIT_RX: begin
        // A byte arriving on the final cycle beats the timeout.
        if (i_rx_done_tick) begin
          result_d       = i_rx_data;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (tmo_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Busy covers the cycle after accept through the cycle before IDLE is re-entered.
    busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= IDX_A;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      busy_q         <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      busy_q         <= busy_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_tx_start     = tx_start_q;
  assign o_tx_data      = tx_data_q;
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_alu_cmd_sender.sv
// tb/tb_alu_cmd_sender.sv - self-checking bench for alu_cmd_sender
module tb_alu_cmd_sender;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TC      = 100;
  localparam int NB_TO   = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [NB_DATA-1:0] i_data_a, i_data_b;
  logic [NB_OP-1:0]   i_operation;
  logic               o_busy, o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid, o_timeout;

  always #5 clk = ~clk;

  alu_cmd_sender #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TC), .NB_TIMEOUT(NB_TO)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_operation(i_operation),
    .o_busy(o_busy), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done_tick(i_tx_done_tick), .i_rx_data(i_rx_data), .i_rx_done_tick(i_rx_done_tick),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_timeout(o_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] last_result = 8'h00;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    int         tx_lat;
    int         rx_after;     // edges after final tx done when rx is sampled; -1 = never
    logic [7:0] rx_data;
    bit         hold;
    bit         stray;
    bit         exp_timeout;
    logic [7:0] exp_result;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference outcome: a response counts only if it lands within the timeout window.
  function automatic bit model_timeout(input int rx_after);
    return (rx_after < 0) || (rx_after > TC);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_tx_start"}, 32'(o_tx_start), 0);
    chk({tag, "_tx_data"}, 32'(o_tx_data), 0);
    chk({tag, "_result"}, 32'(o_result), 0);
    chk({tag, "_valid"}, 32'(o_result_valid), 0);
    chk({tag, "_timeout"}, 32'(o_timeout), 0);
  endtask

  task automatic do_txn(input vec_t v);
    logic [7:0] eb[3];
    int n, tx_cnt, acc, fin_edge, rx_edge, last_done, budget;
    bit pending, finished;
    eb[0] = v.a;
    eb[1] = v.b;
    eb[2] = {2'b00, v.op};
    i_data_a = v.a; i_data_b = v.b; i_operation = v.op;
    i_start = 1'b1;
    tick();
    acc = cyc;
    chk("accept_busy", 32'(o_busy), 0);
    chk("accept_tx_start", 32'(o_tx_start), 0);
    if (!v.hold) i_start = 1'b0;
    n = 0; tx_cnt = 0; fin_edge = -1; rx_edge = -1; last_done = -1;
    pending = 0; finished = 0;
    budget = 3 * (v.tx_lat + 3) + TC + 20;
    for (int i = 0; i < budget && !finished; i++) begin
      tick();
      i_tx_done_tick = 1'b0;
      i_rx_done_tick = 1'b0;
      if (o_result_valid || o_timeout) begin
        finished = 1;
        chk("bytes_sent", 32'(n), 3);
        chk("busy_end", 32'(o_busy), 0);
        if (v.exp_timeout) begin
          chk("timeout_pulse", 32'(o_timeout), 1);
          chk("valid_absent", 32'(o_result_valid), 0);
          chk("timeout_edge", 32'(cyc), 32'(fin_edge + TC));
          chk("result_held", 32'(o_result), 32'(v.exp_result));
        end else begin
          chk("valid_pulse", 32'(o_result_valid), 1);
          chk("timeout_absent", 32'(o_timeout), 0);
          chk("result_edge", 32'(cyc), 32'(rx_edge));
          chk("result_value", 32'(o_result), 32'(v.exp_result));
        end
      end else begin
        chk("busy_mid", 32'(o_busy), 1);
        if (o_tx_start) begin
          chk("tx_count_le3", 32'(n < 3), 1);
          if (n < 3) chk("tx_byte", 32'(o_tx_data), 32'(eb[n]));
          if (n == 0) chk("first_start_edge", 32'(cyc), 32'(acc + 1));
          else        chk("next_start_edge", 32'(cyc), 32'(last_done + 1));
          n++;
          tx_cnt  = v.tx_lat;
          pending = 1;
          if (v.stray && n == 1) begin
            i_rx_done_tick = 1'b1;
            i_rx_data      = 8'hFF;
          end
        end
        if (pending && n >= 1 && n <= 3) chk("tx_data_stable", 32'(o_tx_data), 32'(eb[n-1]));
        if (pending) begin
          tx_cnt--;
          if (tx_cnt <= 0) begin
            i_tx_done_tick = 1'b1;
            pending   = 0;
            last_done = cyc + 1;
            if (n == 3) begin
              fin_edge = cyc + 1;
              if (v.rx_after >= 0) rx_edge = fin_edge + v.rx_after;
            end
          end
        end
        if (rx_edge >= 0 && cyc + 1 == rx_edge) begin
          i_rx_done_tick = 1'b1;
          i_rx_data      = v.rx_data;
        end
      end
    end
    chk("txn_complete", 32'(finished), 1);
    i_tx_done_tick = 1'b0;
    i_rx_done_tick = 1'b0;
    if (!v.exp_timeout) last_result = v.exp_result;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    // a, b, op, tx_lat, rx_after, rx_data, hold, stray, exp_timeout, exp_result
    tbl[0] = '{8'h05, 8'h03, 6'h20, 10, 3,      8'h08, 1'b0, 1'b0, 1'b0, 8'h08};
    tbl[1] = '{8'h11, 8'h22, 6'h3F, 4,  5,      8'h33, 1'b1, 1'b0, 1'b0, 8'h33};
    tbl[2] = '{8'h11, 8'h22, 6'h3F, 4,  5,      8'h34, 1'b0, 1'b0, 1'b0, 8'h34};
    tbl[3] = '{8'h7E, 8'h01, 6'h01, 6,  -1,     8'h00, 1'b0, 1'b0, 1'b1, 8'h34};
    tbl[4] = '{8'h40, 8'h41, 6'h02, 8,  7,      8'h12, 1'b0, 1'b1, 1'b0, 8'h12};
    tbl[5] = '{8'h0C, 8'h0D, 6'h3E, 3,  TC,     8'hAB, 1'b0, 1'b0, 1'b0, 8'hAB};
    tbl[6] = '{8'h01, 8'h02, 6'h03, 2,  TC + 1, 8'hCD, 1'b0, 1'b0, 1'b1, 8'hAB};
    tbl[7] = '{8'hF0, 8'h0F, 6'h15, 1,  TC - 1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A};

    rst_n = 1'b0;
    i_start = 1'b0; i_data_a = '0; i_data_b = '0; i_operation = '0;
    i_tx_done_tick = 1'b0; i_rx_done_tick = 1'b0; i_rx_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_txn(tbl[i]);
    i_start = 1'b0;

    // Reset while waiting for byte B to finish transmitting.
    i_data_a = 8'h99; i_data_b = 8'h98; i_operation = 6'h11;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("rst_seq_byte_a", 32'(o_tx_start), 1);
    i_tx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
    tick();
    chk("rst_seq_byte_b", 32'(o_tx_start), 1);
    chk("rst_seq_data_b", 32'(o_tx_data), 32'h98);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    last_result = 8'h00;
    rv = '{8'hAA, 8'h55, 6'h24, 5, 4, 8'h77, 1'b0, 1'b0, 1'b0, 8'h77};
    do_txn(rv);

    for (int i = 0; i < 24; i++) begin
      rv.a       = 8'($urandom);
      rv.b       = 8'($urandom);
      rv.op      = 6'($urandom);
      rv.tx_lat  = int'($urandom_range(1, 12));
      rv.rx_after = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TC + 10));
      rv.rx_data = 8'($urandom);
      rv.hold    = ($urandom_range(0, 3) == 0);
      rv.stray   = ($urandom_range(0, 2) == 0);
      rv.exp_timeout = model_timeout(rv.rx_after);
      rv.exp_result  = rv.exp_timeout ? last_result : rv.rx_data;
      do_txn(rv);
    end
    i_start = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_tx_start", 32'(o_tx_start), 0);
    chk("idle_result", 32'(o_result), 32'(last_result));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sender.md
# alu_cmd_sender

Host-side command initiator for the UART ALU link. Accepts one (A, B, operation) request, serializes it as three bytes through a `tx_uart` instance, then waits for the single result byte from an `rx_uart` instance. It returns the result, or flags a timeout if no byte arrives. It is the counterpart of the device-side command interface and is used in loopback benches and host-emulation tops.

## Interface

**Parameters**
- `NB_DATA`, 8: UART byte width, also the A/B/result width.
- `NB_OP`, 6: operation code width; must satisfy NB_OP ≤ NB_DATA.
- `TIMEOUT_CYCLES`, 2_000_000: clock cycles allowed in WAIT_RX before timeout; must be ≥ 2.
- `NB_TIMEOUT`, 21: timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES.

**Ports**
- `i_clock`, in, 1: the single system clock.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: request strobe, sampled only in IDLE.
- `i_data_a`, in, NB_DATA: operand A.
- `i_data_b`, in, NB_DATA: operand B.
- `i_operation`, in, NB_OP: ALU opcode.
- `o_busy`, out, 1: high from the cycle after accept until return to IDLE.
- `o_tx_start`, out, 1: one-cycle pulse to `tx_uart`.
- `o_tx_data`, out, NB_DATA: byte presented to `tx_uart`.
- `i_tx_done_tick`, in, 1: byte-sent pulse from `tx_uart`.
- `i_rx_data`, in, NB_DATA: byte from `rx_uart`.
- `i_rx_done_tick`, in, 1: byte-received pulse from `rx_uart`.
- `o_result`, out, NB_DATA: last received result, held between commands.
- `o_result_valid`, out, 1: one-cycle pulse when `o_result` updates.
- `o_timeout`, out, 1: one-cycle pulse on response timeout.

## Operation

- **States:** IDLE, LOAD, WAIT_TX, WAIT_RX.
- **IDLE:** on `i_start`=1, latch A, B and op, set the byte index to 0, and go to LOAD.
- **LOAD:** assert `o_tx_start` for exactly one cycle with `o_tx_data` = the byte at the current index, then go to WAIT_TX.
  - Byte order: index 0 = A, index 1 = B, index 2 = {zeros, op}.
- **WAIT_TX:** on `i_tx_done_tick`:
  - index < 2: increment the index and go to LOAD.
  - index = 2: clear the timeout counter and go to WAIT_RX.
- **WAIT_RX:** the timeout counter increments every cycle.
  - On `i_rx_done_tick`: `o_result` ← `i_rx_data`, pulse `o_result_valid`, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES−1 with no rx tick: pulse `o_timeout`, go to IDLE, `o_result` unchanged.
- **Reset values:** all outputs 0, state IDLE, index 0, counter 0, latched operands 0.

**Boundary conditions**
- `i_start` outside IDLE is ignored; there is no queuing.
- `i_rx_done_tick` outside WAIT_RX is ignored, including stray bytes during transmit.
- `i_tx_done_tick` outside WAIT_TX is ignored.
- rx tick and timeout expiry in the same cycle: the result wins; `o_result_valid`=1, `o_timeout`=0.
- `i_start` in the same cycle the block returns to IDLE is not accepted; it is accepted on the next cycle if still high.
- Reset mid-operation: immediate return to reset values. An in-flight `tx_uart` byte is not aborted by this block; `tx_uart` shares the reset.

## Timing

- Accept at edge k (IDLE, `i_start`=1).
  - Edge k+1: `o_busy`=1, `o_tx_start`=1, `o_tx_data`=A.
  - Edge k+2: `o_tx_start`=0.
- `o_tx_data` is stable from `o_tx_start` until the matching `i_tx_done_tick`.
- Next `o_tx_start` comes 2 cycles after each non-final `i_tx_done_tick`: one edge to enter LOAD, then the pulse.
- `o_result_valid`, `o_result` and `o_busy`=0 all appear the cycle after `i_rx_done_tick`.
- `o_timeout` asserts TIMEOUT_CYCLES cycles after entry to WAIT_RX. `o_busy` falls in that same cycle.
- All outputs are registered; no combinational path from input to output.

## Structure

- Shared package `alu_link_pkg`:
  - state encoding for the four states;
  - byte-index constants IDX_A=0, IDX_B=1, IDX_OP=2;
  - default NB_DATA/NB_OP, which must also be used by the device-side interface.
- One natural sub-module: `timeout_counter`, with clear, enable and an expiry pulse, parameterized by TIMEOUT_CYCLES and NB_TIMEOUT.

## Test plan

1. **Basic ADD.** A=0x05, B=0x03, op=0x20; model `tx_uart` done 10 cycles after each start; rx 0x08 → exactly three `o_tx_start` pulses carrying 0x05, 0x03, 0x20, then `o_result`=0x08 with a one-cycle `o_result_valid`.
2. **Start while busy.** Hold `i_start`=1 during the whole transaction → exactly 3 bytes sent. A second transaction starts only after `o_busy` falls.
3. **Timeout.** TIMEOUT_CYCLES=100, no rx → `o_timeout` pulses 100 cycles after the third `i_tx_done_tick`; `o_result` keeps its prior value; `o_busy`=0.
4. **Stray bytes.** `i_rx_done_tick` with 0xFF during WAIT_TX → ignored; a later rx 0x12 in WAIT_RX → `o_result`=0x12.
5. **Reset mid-transfer.** Assert `i_reset`=0 in WAIT_TX after byte B → all outputs 0 asynchronously. After release, a new A=0xAA, B=0x55, op=0x24 sequence transmits correctly.
6. **Simultaneous events.** rx tick coincides with the final timeout cycle → `o_result_valid`=1, `o_timeout`=0.
